// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared definitions for the 3-digit 7-segment (FND) scan driver.
//   NUM_DIGITS      : number of multiplexed digits on the display
//   SEG_0..SEG_9    : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_DASH        : pattern shown for non-decimal nibbles (g only)
//   SEG_OFF         : all segments dark
//   digit_t         : digit index used by the scanner (ones, tens, hundreds)
// -----------------------------------------------------------------------------
package fnd_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic [1:0] {
        DIGIT_ONES     = 2'd0,
        DIGIT_TENS     = 2'd1,
        DIGIT_HUNDREDS = 2'd2
    } digit_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD nibble to 7-segment decoder, active-high outputs.
// Nibbles 10..15 are not valid BCD and are rendered as a dash so a bad
// upstream value is visible instead of showing a misleading digit.
//   digit : 4-bit BCD nibble
//   seg   : segment pattern {g,f,e,d,c,b,a}, 1 = lit
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import fnd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_fnd_scan.sv
// -----------------------------------------------------------------------------
// bcd_fnd_scan
// Time-multiplexed driver for a 3-digit 7-segment display fed by a packed
// BCD word. The word is snapshotted once per frame so the digits of one
// displayed number always come from the same converter output.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   bcd_in   : {hundreds, tens, ones} BCD nibbles
//   blank_en : leading-zero blanking enable, sampled live
//   seg      : segments {g,f,e,d,c,b,a}
//   dp       : decimal point, never lit
//   an       : digit enables, an[0] = ones .. an[2] = hundreds
// Parameters:
//   SCAN_DIV   : clock cycles per digit slot (>= 2)
//   BLANK_CYC  : dead-time cycles at the start of each slot (< SCAN_DIV)
//   ACTIVE_LOW : 1 = seg/dp/an are active-low, 0 = active-high
// -----------------------------------------------------------------------------
module bcd_fnd_scan
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        blank_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  an
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // XOR masks turn the active-high internal view into the pin polarity.
    localparam logic [6:0]            SEG_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_MASK  = ACTIVE_LOW ? '1 : '0;
    localparam logic                  DP_OFF   = ACTIVE_LOW;

    logic [CNT_W-1:0]      cnt;
    digit_t                idx;
    digit_t                idx_next;
    logic [11:0]           frame;
    logic [3:0]            nibble;
    logic                  digit_blank;
    logic                  slot_open;
    logic [6:0]            seg_dec;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;

    // Digit rotation: ones -> tens -> hundreds -> ones.
    always_comb begin
        idx_next = DIGIT_ONES;
        case (idx)
            DIGIT_ONES: idx_next = DIGIT_TENS;
            DIGIT_TENS: idx_next = DIGIT_HUNDREDS;
            default:    idx_next = DIGIT_ONES;
        endcase
    end

    // Pick the nibble for the current slot and decide leading-zero blanking.
    // Tens only counts as leading when hundreds is also zero; ones is
    // always shown so a value of zero still displays "0".
    always_comb begin
        nibble      = frame[3:0];
        digit_blank = 1'b0;
        case (idx)
            DIGIT_TENS: begin
                nibble      = frame[7:4];
                digit_blank = blank_en && (frame[11:4] == 8'h00);
            end
            DIGIT_HUNDREDS: begin
                nibble      = frame[11:8];
                digit_blank = blank_en && (frame[11:8] == 4'h0);
            end
            default: begin
                nibble      = frame[3:0];
                digit_blank = 1'b0;
            end
        endcase
    end

    // Dead time at the start of each slot lets the previous digit's anode
    // turn fully off before new segments appear (anti-ghosting). With no
    // dead time the comparison would be trivially true, so it is skipped.
    if (BLANK_CYC == 0) begin : g_no_dead_time
        assign slot_open = 1'b1;
    end else begin : g_dead_time
        assign slot_open = (cnt >= CNT_W'(BLANK_CYC));
    end

    bcd_to_seg7 u_decoder (
        .digit (nibble),
        .seg   (seg_dec)
    );

    // Active-high drive for the current cycle; everything dark unless the
    // slot is past its dead time and the digit is not blanked.
    always_comb begin
        seg_raw = SEG_OFF;
        an_raw  = '0;
        if (slot_open && !digit_blank) begin
            seg_raw = seg_dec;
            an_raw  = NUM_DIGITS'(1) << idx;
        end
    end

    // Slot counter, digit index, frame snapshot and registered outputs.
    // The frame reloads on the edge that leaves the hundreds slot, so a new
    // value always starts being shown from the ones digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= DIGIT_ONES;
            frame <= '0;
            seg   <= SEG_OFF ^ SEG_MASK;
            an    <= AN_MASK;
            dp    <= DP_OFF;
        end else begin
            seg <= seg_raw ^ SEG_MASK;
            an  <= an_raw ^ AN_MASK;
            dp  <= DP_OFF;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx_next;
                if (idx == DIGIT_HUNDREDS) begin
                    frame <= bcd_in;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_fnd_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_fnd_scan
// Self-checking bench for bcd_fnd_scan with a short scan (4 cycles per slot,
// 1 dead-time cycle, active-low pins). A cycle-level reference model derived
// from elapsed time since reset is compared against the DUT every cycle,
// and directed literal expectations pin specific display states.
// -----------------------------------------------------------------------------
module tb_bcd_fnd_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME_LEN = 3 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd_in;
    logic        blank_en;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  an;

    int tests_run  = 0;
    int fail_count = 0;
    int cyc        = 0;

    bcd_fnd_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .blank_en (blank_en),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Active-high 7-segment font, {g,f,e,d,c,b,a}; dash for non-BCD.
    function automatic logic [6:0] font(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Whether the digit being scanned t cycles after reset is lit.
    function automatic bit lit(input int t, input logic [11:0] f, input logic be);
        int slot;
        int pos;
        bit blanked;
        slot    = (t / SCAN_DIV) % 3;
        pos     = t % SCAN_DIV;
        blanked = 1'b0;
        if (slot == 2 && be && f[11:8] == 4'h0) blanked = 1'b1;
        if (slot == 1 && be && f[11:4] == 8'h00) blanked = 1'b1;
        return (pos >= BLANK_CYC) && !blanked;
    endfunction

    function automatic logic [2:0] model_an(input int t, input logic [11:0] f, input logic be);
        int slot;
        slot = (t / SCAN_DIV) % 3;
        if (!lit(t, f, be)) return 3'b111;
        return ~(3'b001 << slot);
    endfunction

    function automatic logic [6:0] model_seg(input int t, input logic [11:0] f, input logic be);
        int slot;
        int d;
        slot = (t / SCAN_DIV) % 3;
        d    = int'((f >> (4 * slot)) & 12'hF);
        if (!lit(t, f, be)) return 7'h7F;
        return ~font(d);
    endfunction

    // Reference model: ticks counts cycles since reset release, the shown
    // frame is replaced on the last cycle of every frame period.
    int          ticks       = 0;
    logic [11:0] mframe      = '0;
    logic [2:0]  exp_an      = 3'b111;
    logic [6:0]  exp_seg     = 7'h7F;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ticks       <= 0;
            mframe      <= '0;
            exp_an      <= 3'b111;
            exp_seg     <= 7'h7F;
            model_valid <= 1'b1;
        end else begin
            exp_an  <= model_an(ticks, mframe, blank_en);
            exp_seg <= model_seg(ticks, mframe, blank_en);
            if (ticks % FRAME_LEN == FRAME_LEN - 1) mframe <= bcd_in;
            ticks <= ticks + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            tests_run = tests_run + 1;
            if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
                fail_count = fail_count + 1;
                $display("[TB] FAIL model t=%0t: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                         $time, an, seg, dp, exp_an, exp_seg);
            end
        end
    end

    task automatic applyStimulus(input logic [11:0] value, input logic be);
        bcd_in   = value;
        blank_en = be;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] want_an, input logic [6:0] want_seg);
        #1;
        tests_run = tests_run + 1;
        if (an !== want_an || seg !== want_seg || dp !== 1'b1) begin
            fail_count = fail_count + 1;
            $display("[TB] FAIL %s: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                     name, an, seg, dp, want_an, want_seg);
        end
    endtask

    // Advance to the falling edge numbered target since reset release.
    task automatic goTo(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(12'h999, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset_off", 3'b111, 7'b1111111);

        rst = 1'b0;
        cyc = 0;
        applyStimulus(12'h255, 1'b0);
        goTo(1);  checkOutput("post_reset_dead", 3'b111, 7'b1111111);
        goTo(2);  checkOutput("post_reset_ones0", 3'b110, 7'b1000000);
        goTo(6);  checkOutput("post_reset_tens0", 3'b101, 7'b1000000);
        goTo(14); checkOutput("full_ones5", 3'b110, 7'b0010010);
        goTo(17); checkOutput("full_tens_dead", 3'b111, 7'b1111111);
        goTo(18); checkOutput("full_tens5", 3'b101, 7'b0010010);
        goTo(22); checkOutput("full_hund2", 3'b011, 7'b0100100);

        applyStimulus(12'h007, 1'b1);
        goTo(26); checkOutput("blank_ones7", 3'b110, 7'b1111000);
        goTo(30); checkOutput("blank_tens", 3'b111, 7'b1111111);
        goTo(34); checkOutput("blank_hund", 3'b111, 7'b1111111);

        applyStimulus(12'h107, 1'b1);
        goTo(42); checkOutput("inner_zero_tens", 3'b101, 7'b1000000);
        goTo(46); checkOutput("inner_zero_hund1", 3'b011, 7'b1111001);

        applyStimulus(12'h123, 1'b1);
        goTo(54); applyStimulus(12'h200, 1'b1);
        goTo(55); checkOutput("snap_tens2", 3'b101, 7'b0100100);
        goTo(58); checkOutput("snap_hund1", 3'b011, 7'b1111001);
        goTo(62); checkOutput("snap_next_ones0", 3'b110, 7'b1000000);
        goTo(66); checkOutput("snap_next_tens0", 3'b101, 7'b1000000);
        goTo(70); checkOutput("snap_next_hund2", 3'b011, 7'b0100100);

        applyStimulus(12'h0A0, 1'b0);
        goTo(74); checkOutput("dash_ones0", 3'b110, 7'b1000000);
        goTo(78); checkOutput("dash_tens", 3'b101, 7'b0111111);
        goTo(82); checkOutput("dash_hund0", 3'b011, 7'b1000000);

        goTo(94);
        rst = 1'b1;
        applyStimulus(12'h888, 1'b0);
        @(negedge clk);
        checkOutput("midscan_reset_off", 3'b111, 7'b1111111);
        rst = 1'b0;
        cyc = 0;
        goTo(1);  checkOutput("restart_dead", 3'b111, 7'b1111111);
        goTo(2);  checkOutput("restart_ones0", 3'b110, 7'b1000000);
        goTo(6);  checkOutput("restart_tens0", 3'b101, 7'b1000000);
        goTo(10); checkOutput("restart_hund0", 3'b011, 7'b1000000);
        goTo(14); checkOutput("restart_ones8", 3'b110, 7'b0000000);
        goTo(20);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
